// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side timing checker for an active-high hsync/vsync
// video stream. Measures line period, hsync width, lines per frame and vsync
// width, runs a SEARCH/CHECK/LOCKED lock machine against the expected timing,
// and captures one pixel per frame at a programmable probe point.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 1344,
    parameter int H_SYNC      = 136,
    parameter int V_TOTAL     = 806,
    parameter int V_SYNC      = 6,
    parameter int LOCK_FRAMES = 2,
    parameter int PROBE_X     = 200,
    parameter int PROBE_Y     = 500
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iVGA_Hsync,
    input  logic        iVGA_Vsync,
    input  logic [3:0]  iVGA_Red,
    input  logic [3:0]  iVGA_Green,
    input  logic [3:0]  iVGA_Blue,
    output logic [10:0] oHTotal,
    output logic [10:0] oHSyncWidth,
    output logic [10:0] oVTotal,
    output logic [10:0] oVSyncWidth,
    output logic        oLocked,
    output logic        oError,
    output logic [7:0]  oFrameCount,
    output logic [11:0] oProbeRGB,
    output logic        oProbeValid
);

    localparam logic [10:0] CNT_MAX   = 11'd2047;
    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] PROBE_X_W = 11'(PROBE_X);
    localparam logic [10:0] PROBE_Y_W = 11'(PROBE_Y);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Counters stop at full scale instead of wrapping so a dead input reads as 2047.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    logic        hsync_p1, vsync_p1, hsync_p2, vsync_p2;
    logic [11:0] rgb_p1, rgb_p2;
    logic        hrise_p2, hfall_p2, vrise_p2, vfall_p2;

    logic [10:0] pix, hwidth, line, vwidth;
    logic        seen_rise, frame_bad;
    logic [10:0] period;
    logic        period_bad, width_bad, frame_good, timeout, probe_hit;

    state_t      state, state_next;
    logic [3:0]  good_cnt, good_cnt_next;
    logic        error_next, frame_inc;

    // Stage 1/2: input register, delayed copy, and registered edge flags aligned with the delayed copy.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
            rgb_p1   <= '0;
            hsync_p2 <= 1'b0;
            vsync_p2 <= 1'b0;
            rgb_p2   <= '0;
            hrise_p2 <= 1'b0;
            hfall_p2 <= 1'b0;
            vrise_p2 <= 1'b0;
            vfall_p2 <= 1'b0;
        end else begin
            hsync_p1 <= iVGA_Hsync;
            vsync_p1 <= iVGA_Vsync;
            rgb_p1   <= {iVGA_Red, iVGA_Green, iVGA_Blue};
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
            rgb_p2   <= rgb_p1;
            hrise_p2 <= hsync_p1 & ~hsync_p2;
            hfall_p2 <= ~hsync_p1 & hsync_p2;
            vrise_p2 <= vsync_p1 & ~vsync_p2;
            vfall_p2 <= ~vsync_p1 & vsync_p2;
        end
    end

    // A frame is judged at vsync rise, including any violation measured in that same clock.
    always_comb begin
        period     = sat_inc(pix);
        period_bad = hrise_p2 && seen_rise && (period != H_TOTAL_W);
        width_bad  = hfall_p2 && (hwidth != H_SYNC_W);
        frame_good = !(frame_bad || period_bad || width_bad) &&
                     (line == V_TOTAL_W) && (oVSyncWidth == V_SYNC_W);
        timeout    = (pix == CNT_MAX - 11'd1) && !hrise_p2;
        probe_hit  = (pix == PROBE_X_W) && (line == PROBE_Y_W);
    end

    // Stage 3: measurement counters, latched measurements and probe capture.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            pix         <= '0;
            hwidth      <= '0;
            line        <= '0;
            vwidth      <= '0;
            seen_rise   <= 1'b0;
            frame_bad   <= 1'b0;
            oHTotal     <= '0;
            oHSyncWidth <= '0;
            oVTotal     <= '0;
            oVSyncWidth <= '0;
            oProbeRGB   <= '0;
            oProbeValid <= 1'b0;
        end else begin
            if (hrise_p2) begin
                pix       <= '0;
                seen_rise <= 1'b1;
                if (seen_rise)
                    oHTotal <= period;
            end else begin
                pix <= sat_inc(pix);
                if (timeout)
                    seen_rise <= 1'b0;
            end

            if (hrise_p2)
                hwidth <= 11'd1;
            else if (hsync_p2)
                hwidth <= sat_inc(hwidth);
            if (hfall_p2)
                oHSyncWidth <= hwidth;

            // An hsync coincident with vsync rise is the first line of the new frame.
            if (vrise_p2) begin
                line    <= hrise_p2 ? 11'd1 : 11'd0;
                vwidth  <= hrise_p2 ? 11'd1 : 11'd0;
                oVTotal <= line;
            end else if (hrise_p2) begin
                line <= sat_inc(line);
                if (vsync_p2)
                    vwidth <= sat_inc(vwidth);
            end
            if (vfall_p2)
                oVSyncWidth <= vwidth;

            if (vrise_p2)
                frame_bad <= 1'b0;
            else if (period_bad || width_bad)
                frame_bad <= 1'b1;

            oProbeValid <= probe_hit;
            if (probe_hit)
                oProbeRGB <= rgb_p2;
        end
    end

    // Lock machine next-state: timeout overrides everything, otherwise act on vsync rise.
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        error_next    = 1'b0;
        frame_inc     = 1'b0;
        if (timeout) begin
            state_next    = SEARCH;
            good_cnt_next = '0;
            error_next    = (state == LOCKED);
        end else if (vrise_p2) begin
            case (state)
                SEARCH: begin
                    state_next    = CHECK;
                    good_cnt_next = '0;
                end
                CHECK: begin
                    if (frame_good) begin
                        good_cnt_next = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_N)
                            state_next = LOCKED;
                    end else begin
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (frame_good) begin
                        frame_inc = 1'b1;
                    end else begin
                        error_next    = 1'b1;
                        state_next    = CHECK;
                        good_cnt_next = '0;
                    end
                end
                default: begin
                    state_next    = SEARCH;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

    // Lock machine state register, error pulse and locked-frame counter.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            oError      <= 1'b0;
            oFrameCount <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            oError   <= error_next;
            if (frame_inc)
                oFrameCount <= oFrameCount + 8'd1;
        end
    end

    assign oLocked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor: a scaled-down stream (240 clocks x 8 lines)
// exercises lock, stretched line, short frame, hsync loss and probe capture; a second
// tiny-timing instance runs long enough to wrap the frame counter.
module tb_vga_timing_monitor;

    localparam int HT = 240;
    localparam int HS = 24;
    localparam int VT = 8;
    localparam int VS = 2;
    localparam int PX = 200;
    localparam int PY = 5;

    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic        iReset_n;
    logic        hs, vs;
    logic [3:0]  r, g, b;
    logic [10:0] o_htotal, o_hsw, o_vtotal, o_vsw;
    logic        o_locked, o_error, o_pvalid;
    logic [7:0]  o_fc;
    logic [11:0] o_prgb;

    logic        w_hs, w_vs, w_done;
    logic [10:0] w_htotal, w_hsw, w_vtotal, w_vsw;
    logic        w_locked, w_error, w_pvalid;
    logic [7:0]  w_fc;
    logic [11:0] w_prgb;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
        .LOCK_FRAMES(2), .PROBE_X(PX), .PROBE_Y(PY)
    ) u_dut (
        .iClk(iClk), .iReset_n(iReset_n),
        .iVGA_Hsync(hs), .iVGA_Vsync(vs),
        .iVGA_Red(r), .iVGA_Green(g), .iVGA_Blue(b),
        .oHTotal(o_htotal), .oHSyncWidth(o_hsw), .oVTotal(o_vtotal), .oVSyncWidth(o_vsw),
        .oLocked(o_locked), .oError(o_error), .oFrameCount(o_fc),
        .oProbeRGB(o_prgb), .oProbeValid(o_pvalid)
    );

    vga_timing_monitor #(
        .H_TOTAL(16), .H_SYNC(4), .V_TOTAL(4), .V_SYNC(1),
        .LOCK_FRAMES(2), .PROBE_X(5), .PROBE_Y(2)
    ) u_wrap (
        .iClk(iClk), .iReset_n(iReset_n),
        .iVGA_Hsync(w_hs), .iVGA_Vsync(w_vs),
        .iVGA_Red(4'd0), .iVGA_Green(4'd0), .iVGA_Blue(4'd0),
        .oHTotal(w_htotal), .oHSyncWidth(w_hsw), .oVTotal(w_vtotal), .oVSyncWidth(w_vsw),
        .oLocked(w_locked), .oError(w_error), .oFrameCount(w_fc),
        .oProbeRGB(w_prgb), .oProbeValid(w_pvalid)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int edge_no = 0;
    int last_hrise = 0;
    int frame_idx = 0;
    int vr [0:31];

    // Colour ramp follows the generator's own pixel counter, whose hsync starts at pixel HT-3.
    function automatic logic [11:0] ramp(input int h);
        int p;
        p = (h >= 3) ? h - 3 : h + HT - 3;
        return p[11:0];
    endfunction

    task automatic tick(input logic h, input logic v, input logic [11:0] c);
        hs = h;
        vs = v;
        {r, g, b} = c;
        @(posedge iClk);
        #1;
        edge_no++;
    endtask

    task automatic run_line(input int len, input logic v);
        for (int h = 0; h < len; h++) begin
            tick(h < HS, v, ramp(h));
            if (h == 0) last_hrise = edge_no;
        end
    endtask

    task automatic run_frame(input int lines, input int stretch);
        vr[frame_idx] = edge_no + 1;
        frame_idx++;
        for (int l = 0; l < lines; l++)
            run_line((l == stretch) ? HT + 1 : HT, l < VS);
    endtask

    // Event monitor on the main instance, sampled on the falling edge.
    int          err_cnt = 0;
    int          err_edge = 0;
    int          probe_cnt = 0;
    int          lock_edge = 0;
    logic [11:0] probe_rgb = '0;
    logic        locked_prev = 1'b0;
    always @(negedge iClk) begin
        if (o_error === 1'b1) begin
            err_cnt  <= err_cnt + 1;
            err_edge <= edge_no;
        end
        if (o_pvalid === 1'b1) begin
            probe_cnt <= probe_cnt + 1;
            probe_rgb <= o_prgb;
        end
        if (o_locked === 1'b1 && !locked_prev)
            lock_edge <= edge_no;
        locked_prev <= (o_locked === 1'b1);
    end

    logic [7:0] w_fc_prev = '0;
    logic       saw_wrap = 1'b0;
    always @(negedge iClk) begin
        w_fc_prev <= w_fc;
        if (w_fc_prev == 8'd255 && w_fc == 8'd0)
            saw_wrap <= 1'b1;
    end

    // Tiny-timing generator: 262 frames of 4 lines x 16 clocks, sync rises coincident.
    initial begin
        w_hs = 1'b0;
        w_vs = 1'b0;
        w_done = 1'b0;
        wait (iReset_n === 1'b1);
        for (int f = 0; f < 262; f++)
            for (int l = 0; l < 4; l++)
                for (int h = 0; h < 16; h++) begin
                    w_hs = (h < 4);
                    w_vs = (l < 1);
                    @(posedge iClk);
                    #1;
                end
        w_hs = 1'b0;
        w_vs = 1'b0;
        w_done = 1'b1;
    end

    initial begin
        int n;
        iReset_n = 1'b0;
        hs = 1'b0; vs = 1'b0; r = '0; g = '0; b = '0;
        repeat (3) tick(1'b0, 1'b0, 12'd0);
        check("rst_htotal", o_htotal, 0);
        check("rst_hsw", o_hsw, 0);
        check("rst_vtotal", o_vtotal, 0);
        check("rst_vsw", o_vsw, 0);
        check("rst_locked", o_locked, 0);
        check("rst_error", o_error, 0);
        check("rst_fc", o_fc, 0);
        check("rst_prgb", o_prgb, 0);
        check("rst_pvalid", o_pvalid, 0);
        iReset_n = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 12'd0);

        // Nominal stream: lock two clocks after the third vsync rise.
        run_frame(VT, -1);
        run_frame(VT, -1);
        check("no_lock_before_3rd", o_locked, 0);
        run_frame(VT, -1);
        check("locked_nominal", o_locked, 1);
        check("lock_latency", lock_edge - vr[2], 2);
        check("htotal", o_htotal, HT);
        check("hsync_width", o_hsw, HS);
        check("vtotal_coincident", o_vtotal, VT);
        check("vsync_width", o_vsw, VS);
        check("probe_count", probe_cnt, 3);
        check("probe_rgb", probe_rgb, PX - 2);
        run_frame(VT, -1);
        run_frame(VT, -1);
        check("frame_count", o_fc, 2);
        check("no_error_nominal", err_cnt, 0);

        // One line stretched by a clock: one error, drop lock, relock two frames later.
        run_frame(VT, 3);
        run_frame(VT, -1);
        check("stretch_err_cnt", err_cnt, 1);
        check("stretch_err_latency", err_edge - vr[6], 2);
        check("stretch_unlocked", o_locked, 0);
        run_frame(VT, -1);
        run_frame(VT, -1);
        check("relock_latency", lock_edge - vr[8], 2);
        check("relock_fc", o_fc, 3);

        // Frame one line short.
        run_frame(VT - 1, -1);
        run_frame(VT, -1);
        check("short_vtotal", o_vtotal, VT - 1);
        check("short_err_cnt", err_cnt, 2);
        check("short_unlocked", o_locked, 0);
        run_frame(VT, -1);
        run_frame(VT, -1);
        check("short_relocked", o_locked, 1);
        check("short_fc", o_fc, 4);

        // Hsync stops while locked.
        n = 0;
        while (err_cnt == 2 && n < 3000) begin
            tick(1'b0, 1'b0, 12'd0);
            n++;
        end
        check("timeout_err_cnt", err_cnt, 3);
        check("timeout_latency", err_edge - last_hrise, 2049);
        check("timeout_unlocked", o_locked, 0);

        // Restart: three vsync rises to lock again.
        run_frame(VT, -1);
        run_frame(VT, -1);
        check("restart_not_yet", o_locked, 0);
        run_frame(VT, -1);
        check("restart_lock_latency", lock_edge - vr[15], 2);
        run_frame(5, -1);
        check("restart_fc", o_fc, 5);
        check("final_probe_count", probe_cnt, 17);
        check("final_probe_rgb", probe_rgb, PX - 2);
        check("final_vtotal", o_vtotal, VT);
        check("final_err_cnt", err_cnt, 3);

        // Frame counter wrap on the tiny-timing instance: 259 locked frames -> 3.
        check("wrap_done", w_done, 1);
        check("wrap_seen", saw_wrap, 1);
        check("wrap_fc", w_fc, 3);

        // Asynchronous reset mid-frame, between clock edges.
        check("pre_reset_locked", o_locked, 1);
        #3;
        iReset_n = 1'b0;
        #1;
        check("async_rst_locked", o_locked, 0);
        check("async_rst_htotal", o_htotal, 0);
        check("async_rst_fc", o_fc, 0);
        check("async_rst_vtotal", o_vtotal, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
